// File: rtl/push_pkg.sv
// Shared types and constants for the push-button conditioner.
// Auto-repeat is enabled by defining PUSH_AUTOREPEAT_EN.
package push_pkg;

    localparam int unsigned PUSH_CH          = 4;
    localparam int unsigned DEBOUNCE_DEF     = 500000;
    localparam int unsigned REPEAT_DELAY_DEF = 25000000;
    localparam int unsigned REPEAT_RATE_DEF  = 5000000;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        REPEAT   = 2'd2
    } push_state_e;

endpackage

// File: rtl/push_conditioner_if.sv
// Button bundle between the board pins and the conditioner.
// The master drives the raw buttons; the slave returns the conditioned events.
interface push_conditioner_if;
    import push_pkg::*;

    logic [PUSH_CH-1:0] PUSH;
    logic [PUSH_CH-1:0] LEVEL;
    logic [PUSH_CH-1:0] PRESS;
    logic [PUSH_CH-1:0] RELEASE;

    modport master (
        output PUSH,
        input  LEVEL,
        input  PRESS,
        input  RELEASE
    );

    modport slave (
        input  PUSH,
        output LEVEL,
        output PRESS,
        output RELEASE
    );

endinterface

// File: rtl/push_channel.sv
// One button channel: 2-flop synchroniser, debounce, press/release FSM.
// Auto-repeat states and counter exist only with PUSH_AUTOREPEAT_EN.
module push_channel
    import push_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF,
    parameter bit          PUSH_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] D_TERM = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);

`ifdef PUSH_AUTOREPEAT_EN
    localparam int unsigned RMAX =
        (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] R_DLY  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_RATE = RW'(REPEAT_RATE - 1);
    localparam logic [RW-1:0] R_ONE  = RW'(1);

    logic [RW-1:0] rcnt_q;
`else
    localparam int unsigned unused_rpt = REPEAT_DELAY ^ REPEAT_RATE;
`endif

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;
    logic          pressed;
    logic          diff;
    logic          flip;
    push_state_e   state_q;
    logic          press_q;
    logic          release_q;

    // Synchroniser idles at the raw released level for either polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= PUSH_ACTIVE_LOW;
            sync2_q <= PUSH_ACTIVE_LOW;
        end else begin
            sync1_q <= push_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ PUSH_ACTIVE_LOW;

    always_comb begin
        diff     = (pressed != stable_q);
        flip     = diff && (dcnt_q == D_TERM);
        stable_d = stable_q ^ flip;
        dcnt_d   = '0;
        if (diff && !flip) begin
            dcnt_d = dcnt_q + D_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
        end
    end

    // Pulses are issued on the same edge the debounced level flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef PUSH_AUTOREPEAT_EN
            rcnt_q    <= '0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            unique case (state_q)
                RELEASED: begin
                    if (flip && !stable_q) begin
                        state_q <= HELD;
                        press_q <= 1'b1;
`ifdef PUSH_AUTOREPEAT_EN
                        rcnt_q  <= '0;
`endif
                    end
                end
                HELD, REPEAT: begin
                    if (flip && stable_q) begin
                        state_q   <= RELEASED;
                        release_q <= 1'b1;
`ifdef PUSH_AUTOREPEAT_EN
                        rcnt_q    <= '0;
`endif
                    end
`ifdef PUSH_AUTOREPEAT_EN
                    else if (rcnt_q ==
                             ((state_q == HELD) ? R_DLY : R_RATE)) begin
                        state_q <= REPEAT;
                        press_q <= 1'b1;
                        rcnt_q  <= '0;
                    end else begin
                        rcnt_q <= rcnt_q + R_ONE;
                    end
`endif
                end
                default: begin
                    state_q <= RELEASED;
                end
            endcase
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/push_conditioner.sv
// Four independent debounced button channels feeding the pong bar logic.
// Define PUSH_AUTOREPEAT_EN to enable auto-repeat PRESS pulses.
module push_conditioner
    import push_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF,
    parameter bit          PUSH_ACTIVE_LOW = 1'b0
) (
    input  logic               CLK,
    input  logic               RSTn,
    push_conditioner_if.slave  bus
);

    logic [PUSH_CH-1:0] level_w;
    logic [PUSH_CH-1:0] press_w;
    logic [PUSH_CH-1:0] release_w;

    for (genvar i = 0; i < PUSH_CH; i++) begin : g_ch
        push_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE),
            .PUSH_ACTIVE_LOW (PUSH_ACTIVE_LOW)
        ) u_ch (
            .clk       (CLK),
            .rst_n     (RSTn),
            .push_i    (bus.PUSH[i]),
            .level_o   (level_w[i]),
            .press_o   (press_w[i]),
            .release_o (release_w[i])
        );
    end

    assign bus.LEVEL   = level_w;
    assign bus.PRESS   = press_w;
    assign bus.RELEASE = release_w;

endmodule
